// File: rtl/mem_pkg.sv
// Shared types and encodings for the MIPS memory-access (MEM) stage.
package mem_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    // Bit positions inside m_MEM and wb_MEM
    localparam int M_BRANCH      = 2;
    localparam int M_READ        = 1;
    localparam int M_WRITE       = 0;
    localparam int WB_REG_WRITE  = 1;
    localparam int WB_MEM_TO_REG = 0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/mem_lane_align.sv
// Sub-word lane handling: byte enables, store replication, load extract/extend.
// Only compiled when MEM_BYTE_ACCESS_EN is defined.
`ifdef MEM_BYTE_ACCESS_EN
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  be,
    output logic [31:0] store_lanes,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  b8;
    logic [15:0] h16;

    always_comb begin
        be          = 4'hF;
        store_lanes = store_data;
        load_data   = load_word;
        misaligned  = 1'b0;
        b8          = load_word[{addr_lo, 3'b000} +: 8];
        h16         = load_word[{addr_lo[1], 4'b0000} +: 16];
        case (size)
            SIZE_BYTE: begin
                be          = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = is_unsigned ? {24'h0, b8} : {{24{b8[7]}}, b8};
            end
            SIZE_HALF: begin
                misaligned  = addr_lo[0];
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = is_unsigned ? {16'h0, h16} : {{16{h16[15]}}, h16};
            end
            default: misaligned = (addr_lo != 2'b00);
        endcase
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM inputs -> req/ack data memory -> MEM/WB register, with stall and timeout.
// Define MEM_BYTE_ACCESS_EN for byte/halfword accesses (adds mem_size, mem_unsigned).
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       res,
    input  logic [31:0]       write_data_ex,
    input  logic [4:0]        write_register_ex,
    input  logic              zero,
    input  logic [2:0]        m_MEM,
    input  logic [1:0]        wb_MEM,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
`ifdef MEM_BYTE_ACCESS_EN
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
`endif
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_be,
    output logic              stall_mem,
    output logic              pc_src,
    output logic [4:0]        rd_WB,
    output logic              wb_WB,
    output logic [31:0]       write_data_reg,
    output logic              addr_err,
    output logic              bus_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [7:0]        cnt;
    logic              after_rst;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, res_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [4:0]        rd_q;
    logic [1:0]        wb_q;
    logic [31:0]       read_data_wb, res_wb;
    logic              mem_to_reg_wb;

    logic              in_wait, mem_op, is_store, misaligned, start, done, timeout;
    logic [3:0]        be_cur;
    logic [31:0]       wdata_cur, load_val, fin_res;
    logic [ADDR_W-1:0] addr_cur;
    logic [4:0]        fin_rd;
    logic [1:0]        fin_wb;
    logic              fin_store;

    assign in_wait  = (state == WAIT);
    assign mem_op   = m_MEM[M_READ] | m_MEM[M_WRITE];
    assign is_store = m_MEM[M_WRITE];
    assign addr_cur = {res[ADDR_W-1:2], 2'b00};

`ifdef MEM_BYTE_ACCESS_EN
    logic [1:0] size_q, lo_q;
    logic       uns_q;

    // In WAIT the lane selectors come from the latched request, not the held inputs
    mem_lane_align u_lane (
        .size        (in_wait ? size_q : mem_size),
        .is_unsigned (in_wait ? uns_q  : mem_unsigned),
        .addr_lo     (in_wait ? lo_q   : res[1:0]),
        .store_data  (write_data_ex),
        .load_word   (dmem_rdata),
        .be          (be_cur),
        .store_lanes (wdata_cur),
        .load_data   (load_val),
        .misaligned  (misaligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q <= SIZE_WORD;
            lo_q   <= 2'b00;
            uns_q  <= 1'b0;
        end else if (start) begin
            size_q <= mem_size;
            lo_q   <= res[1:0];
            uns_q  <= mem_unsigned;
        end
    end
`else
    assign misaligned = (res[1:0] != 2'b00);
    assign be_cur     = 4'hF;
    assign wdata_cur  = write_data_ex;
    assign load_val   = dmem_rdata;
`endif

    // The cycle right after reset never starts an access, so a stray ack is ignored
    assign start   = (state == IDLE) && !after_rst && mem_op && !misaligned;
    assign done    = (start || in_wait) && dmem_ack;
    assign timeout = in_wait && !dmem_ack && (cnt == CNT_LAST);

    assign dmem_req   = start || in_wait;
    assign dmem_we    = start ? is_store  : we_q;
    assign dmem_addr  = start ? addr_cur  : addr_q;
    assign dmem_wdata = start ? wdata_cur : wdata_q;
    assign dmem_be    = start ? be_cur : (in_wait ? be_q : 4'h0);

    assign stall_mem      = (dmem_req && !dmem_ack && !timeout) || (after_rst && mem_op);
    assign addr_err       = (state == IDLE) && !after_rst && mem_op && misaligned;
    assign bus_err        = timeout;
    assign pc_src         = m_MEM[M_BRANCH] & zero & ~stall_mem;
    assign write_data_reg = mem_to_reg_wb ? read_data_wb : res_wb;

    assign fin_rd    = in_wait ? rd_q  : write_register_ex;
    assign fin_wb    = in_wait ? wb_q  : wb_MEM;
    assign fin_res   = in_wait ? res_q : res;
    assign fin_store = in_wait ? we_q  : is_store;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
        after_rst <= rst;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !dmem_ack) state_nxt = WAIT;
            WAIT:    if (dmem_ack || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 8'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            rd_q    <= 5'd0;
            wb_q    <= 2'b00;
            res_q   <= 32'h0;
        end else if (start) begin
            cnt     <= 8'd0;
            addr_q  <= addr_cur;
            wdata_q <= wdata_cur;
            we_q    <= is_store;
            be_q    <= be_cur;
            rd_q    <= write_register_ex;
            wb_q    <= wb_MEM;
            res_q   <= res;
        end else if (in_wait) begin
            cnt <= cnt + 8'd1;
        end
    end

    // MEM/WB register: pass-through, completed access, or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_WB         <= 5'd0;
            wb_WB         <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            res_wb        <= 32'h0;
            read_data_wb  <= 32'h0;
        end else if (state == IDLE && !mem_op) begin
            rd_WB         <= write_register_ex;
            wb_WB         <= wb_MEM[WB_REG_WRITE];
            mem_to_reg_wb <= wb_MEM[WB_MEM_TO_REG];
            res_wb        <= res;
        end else if (done) begin
            rd_WB         <= fin_rd;
            wb_WB         <= fin_wb[WB_REG_WRITE];
            mem_to_reg_wb <= fin_wb[WB_MEM_TO_REG];
            res_wb        <= fin_res;
            if (!fin_store) read_data_wb <= load_val;
        end else begin
            wb_WB <= 1'b0;
        end
    end

endmodule
